button_debounce_arbiter: RTL and testbench

- Debounces N_BTN raw pushbuttons using a single shared debounce counter, time-multiplexed by a round-robin scanner.
- Each button that completes a debounced rising edge produces a one-cycle press pulse and is latched as a pending event.
- Pending events are presented one at a time on a valid/ready event port, also in round-robin order.
- Sits between the board pushbuttons and the top-level control FSM; replaces one debouncer per button.

---
 rtl/button_debounce_arbiter.sv | 157 +++++++++++++++
 tb/tb_button_debounce_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_arbiter.sv
// Debounces N_BTN pushbuttons through one shared counter. A round-robin scanner
// lends the counter to one button at a time. Each debounced press is latched as
// a pending event, and pending events are offered one at a time, in round-robin
// order, on a valid/ready port.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   btn_raw      raw button levels, 1 = pressed
//   stable       debounced level per button
//   press_pulse  one-cycle pulse on a debounced 0->1 commit
//   evt_valid    at least one press is pending
//   evt_idx      index of the pending press being offered
//   evt_ready    consumer accepts the event when evt_valid & evt_ready
//   evt_overflow sticky: a press was dropped because its button was already pending
module button_debounce_arbiter #(
   parameter int unsigned      N_BTN   = 5,
   parameter int unsigned      CNT_W   = 16,
   parameter logic [CNT_W-1:0] DEB_MAX = 16'hFFFF,
   parameter int unsigned      IDX_W   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] stable,
   output logic [N_BTN-1:0] press_pulse,
   output logic             evt_valid,
   output logic [IDX_W-1:0] evt_idx,
   input  logic             evt_ready,
   output logic             evt_overflow
);

   typedef enum logic [1:0] {StScan, StCount, StCommit} state_e;

   state_e           state_q;
   logic [N_BTN-1:0] sync1_q, sync2_q;
   logic [N_BTN-1:0] stable_q, pulse_q;
   logic [N_BTN-1:0] pending_q, pending_d;
   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] scan_ptr_q, evt_ptr_q, cur_q;
   logic             ovf_q;

   logic [N_BTN-1:0] scan_diff;
   logic [IDX_W-1:0] scan_idx;
   logic [N_BTN-1:0] commit_set, consume;
   logic             drop;

   // Pointers are always < N_BTN, so a single conditional subtract wraps them.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] ptr,
                                                 input int unsigned k);
      int unsigned sum;
      sum = 32'(ptr) + k;
      if (sum >= N_BTN) sum = sum - N_BTN;
      return IDX_W'(sum);
   endfunction

   // First set bit of req at or above ptr, wrapping; 0 when req is empty.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_BTN-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
      logic             found;
      logic [IDX_W-1:0] idx, j;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 0; k < N_BTN; k++) begin
         j = wrap_add(ptr, k);
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = j;
         end
      end
      return idx;
   endfunction

   always_comb begin
      scan_diff = sync2_q ^ stable_q;
      scan_idx  = rr_pick(scan_diff, scan_ptr_q);
   end

   assign evt_valid = |pending_q;
   assign evt_idx   = rr_pick(pending_q, evt_ptr_q);

   // A commit-set wins over a same-cycle consume of the same bit.
   always_comb begin
      commit_set = '0;
      consume    = '0;
      if (state_q == StCommit && !stable_q[cur_q]) commit_set[cur_q] = 1'b1;
      if (evt_valid && evt_ready) consume[evt_idx] = 1'b1;
      pending_d = (pending_q & ~consume) | commit_set;
      drop      = |(commit_set & pending_q & ~consume);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StScan;
         stable_q   <= '0;
         pulse_q    <= '0;
         cnt_q      <= '0;
         scan_ptr_q <= '0;
         cur_q      <= '0;
      end else begin
         pulse_q <= '0;
         unique case (state_q)
            StScan: begin
               if (|scan_diff) begin
                  cur_q   <= scan_idx;
                  cnt_q   <= '0;
                  state_q <= StCount;
               end
            end
            StCount: begin
               if (sync2_q[cur_q] == stable_q[cur_q]) begin
                  scan_ptr_q <= wrap_add(cur_q, 1);
                  state_q    <= StScan;
               end else if (cnt_q == DEB_MAX) begin
                  state_q <= StCommit;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StCommit: begin
               stable_q[cur_q] <= ~stable_q[cur_q];
               if (!stable_q[cur_q]) pulse_q[cur_q] <= 1'b1;
               scan_ptr_q <= wrap_add(cur_q, 1);
               state_q    <= StScan;
            end
            default: state_q <= StScan;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
         evt_ptr_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         if (evt_valid && evt_ready) evt_ptr_q <= wrap_add(evt_idx, 1);
         if (drop) ovf_q <= 1'b1;
      end
   end

   assign stable       = stable_q;
   assign press_pulse  = pulse_q;
   assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_button_debounce_arbiter.sv
module tb_button_debounce_arbiter;

   localparam int unsigned N_BTN = 5;
   localparam int unsigned IDX_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] stable;
   logic [N_BTN-1:0] press_pulse;
   logic             evt_valid;
   logic [IDX_W-1:0] evt_idx;
   logic             evt_ready;
   logic             evt_overflow;

   button_debounce_arbiter #(
      .N_BTN  (N_BTN),
      .CNT_W  (16),
      .DEB_MAX(16'd7),
      .IDX_W  (IDX_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .stable      (stable),
      .press_pulse (press_pulse),
      .evt_valid   (evt_valid),
      .evt_idx     (evt_idx),
      .evt_ready   (evt_ready),
      .evt_overflow(evt_overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [N_BTN-1:0] val;
      int               at;
   } exp_pulse_t;

   exp_pulse_t pq[$];
   int         eq[$];
   exp_pulse_t e;
   int         ev;
   int         n_cmp = 0;
   int         n_err = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_stable"}, 32'(stable), 32'd0);
      check({tag, "_pulse"}, 32'(press_pulse), 32'd0);
      check({tag, "_valid"}, 32'(evt_valid), 32'd0);
      check({tag, "_idx"}, 32'(evt_idx), 32'd0);
      check({tag, "_ovf"}, 32'(evt_overflow), 32'd0);
   endtask

   // Monitor: every pulse and every accepted event is matched against the queues.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (press_pulse != '0) begin
               if (pq.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_pulse: got %b at cycle %0d, required none",
                           press_pulse, cyc);
               end else begin
                  e = pq.pop_front();
                  check("pulse_val", 32'(press_pulse), 32'(e.val));
                  check("pulse_cycle", cyc, e.at);
               end
            end
            if (evt_valid && evt_ready) begin
               if (eq.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_event: got idx %0d at cycle %0d, required none",
                           evt_idx, cyc);
               end else begin
                  ev = eq.pop_front();
                  check("event_idx", 32'(evt_idx), ev);
               end
            end
         end
      end
   end

   initial begin
      rst       = 1'b1;
      btn_raw   = '0;
      evt_ready = 1'b0;
      tick(3);
      check_cleared("por");
      rst = 1'b0;
      tick(2);

      // Clean press of button 2: pulse 12 edges after the first sampling edge.
      btn_raw[2] = 1'b1;
      pq.push_back('{5'b00100, cyc + 12});
      eq.push_back(2);
      tick(11);
      check("press2_stable_early", 32'(stable[2]), 32'd0);
      tick(1);
      check("press2_stable", 32'(stable[2]), 32'd1);
      tick(1);
      check("press2_pulse_one_cycle", 32'(press_pulse), 32'd0);
      check("press2_valid", 32'(evt_valid), 32'd1);
      check("press2_idx", 32'(evt_idx), 32'd2);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      check("press2_drained", 32'(evt_valid), 32'd0);

      // Release of button 2: stable falls, no pulse, nothing pending.
      tick(2);
      btn_raw[2] = 1'b0;
      tick(11);
      check("rel2_stable_early", 32'(stable[2]), 32'd1);
      tick(1);
      check("rel2_stable", 32'(stable[2]), 32'd0);
      tick(1);
      check("rel2_no_pending", 32'(evt_valid), 32'd0);

      // Bounce on button 1: high 5, low 3, then held high.
      btn_raw[1] = 1'b1;
      tick(5);
      btn_raw[1] = 1'b0;
      tick(3);
      btn_raw[1] = 1'b1;
      pq.push_back('{5'b00010, cyc + 12});
      eq.push_back(1);
      tick(14);
      check("bounce_stable", 32'(stable), 32'b00010);
      check("bounce_valid", 32'(evt_valid), 32'd1);
      check("bounce_idx", 32'(evt_idx), 32'd1);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;

      // Collision: second press of button 2 commits on the edge it is accepted.
      btn_raw[2] = 1'b1;
      pq.push_back('{5'b00100, cyc + 12});
      eq.push_back(2);
      tick(14);
      check("coll_first_idx", 32'(evt_idx), 32'd2);
      btn_raw[2] = 1'b0;
      tick(14);
      check("coll_released", 32'(stable[2]), 32'd0);
      btn_raw[2] = 1'b1;
      pq.push_back('{5'b00100, cyc + 12});
      eq.push_back(2);
      tick(11);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      check("coll_pending_kept", 32'(evt_valid), 32'd1);
      check("coll_idx", 32'(evt_idx), 32'd2);
      check("coll_no_ovf", 32'(evt_overflow), 32'd0);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      check("coll_drained", 32'(evt_valid), 32'd0);

      // Reset in the middle of a count on button 3: no pulse, state cleared.
      btn_raw[3] = 1'b1;
      tick(7);
      btn_raw = '0;
      #3;
      rst = 1'b1;
      #1;
      check_cleared("midrst");
      repeat (2) @(posedge clk);
      #5;
      rst = 1'b0;
      tick(1);
      for (int i = 0; i < 50; i++) begin
         check("idle_valid", 32'(evt_valid), 32'd0);
         tick(1);
      end

      // Round-robin: buttons 0, 3, 4 together commit 10 cycles apart.
      btn_raw = 5'b11001;
      pq.push_back('{5'b00001, cyc + 12});
      pq.push_back('{5'b01000, cyc + 22});
      pq.push_back('{5'b10000, cyc + 32});
      eq.push_back(0);
      eq.push_back(3);
      eq.push_back(4);
      tick(34);
      check("rr_stable", 32'(stable), 32'b11001);
      check("rr_valid", 32'(evt_valid), 32'd1);
      check("rr_idx", 32'(evt_idx), 32'd0);
      check("rr_no_ovf", 32'(evt_overflow), 32'd0);

      // Overflow: re-press button 3 while it is still pending.
      btn_raw[3] = 1'b0;
      tick(14);
      check("ovf_released", 32'(stable[3]), 32'd0);
      btn_raw[3] = 1'b1;
      pq.push_back('{5'b01000, cyc + 12});
      tick(14);
      check("ovf_set", 32'(evt_overflow), 32'd1);
      check("ovf_stable", 32'(stable[3]), 32'd1);

      // Drain: 0, 3, 4 on consecutive accepts.
      evt_ready = 1'b1;
      tick(3);
      evt_ready = 1'b0;
      check("drain_empty", 32'(evt_valid), 32'd0);
      tick(5);
      check("ovf_sticky", 32'(evt_overflow), 32'd1);

      check("pulses_outstanding", pq.size(), 0);
      check("events_outstanding", eq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
